// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter shared types and sizes.
// Used by the arbiter top and its round-robin picker.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_W = 13;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker, purely combinational.
// On a tie the port that did not win last time is chosen.
module rr_arb2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       update,
  input  port_t      last,
  output logic [1:0] gnt
);

  // pick one requester; nothing is granted while update is low
  always_comb begin
    gnt = 2'b00;
    if (update) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single RAM port between CPU (A) and DMA (B).
// Optionally zero-fills the RAM after reset before any grant.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = SRAM_ADDR_W,
  parameter int DATA_W         = SRAM_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_done,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  port_t             last;
  logic [1:0]        gnt;
  logic              run_en;

  // grants are only allowed in RUN and never while reset is held
  assign run_en = (state == ST_RUN) && !reset;

  rr_arb2 u_arb (
    .req    ({b_req, a_req}),
    .update (run_en),
    .last   (last),
    .gnt    (gnt)
  );

  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign init_done = (state == ST_RUN);
  assign a_rdata   = ram_dout;
  assign b_rdata   = ram_dout;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

  // state register and clear sweep counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // leave CLEAR after the write to the last address
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == '1) state_nxt = ST_RUN;
  end

  // RAM pin mux: clear sweep or the granted requester
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = b_gnt ? b_addr : a_addr;
    ram_din = b_gnt ? b_wdata : a_wdata;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_ce  = 1'b1;
        ram_wre = 1'b1;
        ram_ad  = clr_cnt;
        ram_din = '0;
      end else begin
        ram_ce  = a_gnt | b_gnt;
        ram_wre = (a_gnt & a_we) | (b_gnt & b_we);
      end
    end
  end

  // last-grant pointer moves only when something is granted
  always_ff @(posedge clk) begin
    if (reset) last <= PORT_B;
    else if (a_gnt) last <= PORT_A;
    else if (b_gnt) last <= PORT_B;
  end

  // read data returns one cycle after a granted read
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
    end
  end

endmodule
